// File: rtl/addec_table_if.sv
// addec_table_if: lookup and write bus between the CPU address side and the decode table
interface addec_table_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
);
  logic              lkp_en;
  logic [ADDR_W-1:0] lkp_addr;
  logic [DATA_W-1:0] q;
  logic              q_valid;
  logic              ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  modport master (output lkp_en, lkp_addr, wr_en, wr_addr, wr_data, input q, q_valid, ready);
  modport slave  (input lkp_en, lkp_addr, wr_en, wr_addr, wr_data, output q, q_valid, ready);
endinterface

// File: rtl/addec_table.sv
// addec_table: programmable address-decode table, filled with DEFAULT_Q after reset, 1-cycle registered lookups
module addec_table #(
  parameter int unsigned        ADDR_W    = 5,
  parameter int unsigned        DATA_W    = 8,
  parameter logic [DATA_W-1:0]  DEFAULT_Q = 8'hE1,
  parameter bit                 IGNORE_A0 = 1'b0
) (
  input  logic           clock,
  input  logic           reset,
  addec_table_if.slave   bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] A_MASK = {{(ADDR_W-1){1'b1}}, !IGNORE_A0};
  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t            r_state;
  logic [ADDR_W:0]   r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;
  logic              r_q_valid;
  logic              r_ready;
  logic [ADDR_W-1:0] w_lkp_addr;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W:0]   w_cnt_nxt;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  assign w_lkp_addr = bus.lkp_addr & A_MASK;
  assign w_wr_addr  = bus.wr_addr & A_MASK;
  assign w_cnt_nxt  = r_cnt + (ADDR_W+1)'(1);
  assign w_we       = (r_state == S_INIT) || bus.wr_en;
  assign w_waddr    = (r_state == S_INIT) ? r_cnt[ADDR_W-1:0] : w_wr_addr;
  assign w_wdata    = (r_state == S_INIT) ? DEFAULT_Q : bus.wr_data;
  // Nonblocking write alongside the registered read gives read-before-write on collisions
  always_ff @(posedge clock)
    if (!reset && w_we) r_mem[w_waddr] <= w_wdata;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_INIT;
      r_cnt     <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_ready   <= 1'b0;
    end else if (r_state == S_INIT) begin
      r_cnt     <= w_cnt_nxt;
      r_q_valid <= 1'b0;
      if (w_cnt_nxt[ADDR_W]) begin
        r_state <= S_RUN;
        r_ready <= 1'b1;
      end
    end else begin
      r_q_valid <= bus.lkp_en;
      if (bus.lkp_en) r_q <= r_mem[w_lkp_addr];
    end
  end
  assign bus.q       = r_q;
  assign bus.q_valid = r_q_valid;
  assign bus.ready   = r_ready;
endmodule

// File: doc/addec_table.md
Name: addec_table

Overview:
- Parametrised, run-time programmable address-decode table that generalises the fixed 32x8 decode PROM.
- Holds DEPTH entries of DATA_W bits, answers registered lookups with 1-cycle latency, and accepts host writes to reprogram entries.
- A reset-time init sequencer fills every entry with DEFAULT_Q before lookups are accepted.
- Sits between the CPU address bus and the chip-select / strobe fan-out.

Parameters:
- ADDR_W, 5, lookup/write address width; DEPTH = 2**ADDR_W.
- DATA_W, 8, decode word width.
- DEFAULT_Q, 8'hE1, value written to every entry during init (DATA_W bits).
- IGNORE_A0, 0, when 1 bit 0 of lkp_addr and wr_addr is forced to 0 (paired-entry decode); writes then land on the even entry only.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- lkp_en  in  1  lookup request, sampled only when ready=1.
- lkp_addr  in  ADDR_W  lookup address.
- q  out  DATA_W  decode word; holds its last value between lookups.
- q_valid  out  1  one-cycle pulse, q updated this cycle.
- ready  out  1  high in RUN state.
- wr_en  in  1  table write strobe, honoured only when ready=1.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.

Behaviour:
- Reset (reset=1 at a clock edge):
  - q=0, q_valid=0, ready=0, init counter=0, state=INIT.
  - Any in-flight lookup is dropped.
  - Reset asserted mid-INIT or mid-RUN restarts INIT from entry 0.
- INIT state:
  - Each cycle, write DEFAULT_Q to entry[cnt], then cnt++.
  - Takes exactly DEPTH cycles.
  - After the cycle writing entry DEPTH-1, state=RUN and ready=1 on the next cycle.
  - lkp_en and wr_en are ignored; q_valid stays 0 and q stays 0.
- RUN state:
  - Lookup: lkp_en=1 at edge N gives q=entry[eff_lkp_addr] and q_valid=1 after edge N+1 (1-cycle latency).
  - Back-to-back lookups produce back-to-back q_valid pulses.
  - No lookup: q_valid=0 and q holds.
- Write:
  - wr_en=1 at edge N updates entry[eff_wr_addr] at edge N.
  - A lookup issued at edge N+1 or later sees the new data.
- Simultaneous lookup and write to the same effective address in the same cycle: read-before-write. q returns the old entry; the new value is visible from the next lookup.
- Address effective value: eff_addr = IGNORE_A0 ? {addr[ADDR_W-1:1],1'b0} : addr.
- Storage:
  - Plain register array, inferable as distributed/block RAM with a synchronous read.
  - No X propagation after INIT; every entry is defined.
- FSM has two states, INIT and RUN. The transition INIT->RUN is the only non-reset transition.
- The init counter is ADDR_W+1 bits wide so the terminal count DEPTH is detectable without wrap.

Test Plan:
- Reset then release:
  - ready=0 for exactly 32 cycles, ready=1 on cycle 33.
  - Lookups of addr 0x00, 0x0F, 0x1F each return q=0xE1, with q_valid one cycle after lkp_en.
- Program a table:
  - Write entries 0x00..0x1F with a known pattern (e.g. 0x10=0xE0, 0x12=0xE8, 0x1E=0xEE).
  - Read every entry back in 32 back-to-back lookups; expect 32 consecutive q_valid pulses with matching data.
- Same-cycle collision:
  - Entry 0x05=0x41; in one cycle wr_en (0x05, 0x81) and lkp_en (0x05) -> q=0x41.
  - Next lookup of 0x05 -> q=0x81.
- Requests during INIT:
  - Hold lkp_en=1 and wr_en=1 (0x03, 0x55) through INIT -> q_valid never asserts.
  - After ready, lookup 0x03 returns 0xE1.
- Reset mid-operation:
  - Write 0x0A=0x21, assert reset for 1 cycle during a lookup -> q=0, q_valid=0 next cycle, ready low for 32 cycles.
  - Then lookup 0x0A returns 0xE1.
- IGNORE_A0=1:
  - Write 0x09=0xC1 (lands on 0x08).
  - Lookups of 0x08 and 0x09 both return 0xC1; hold lkp_en low 3 cycles -> q stays 0xC1, q_valid=0.
